// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the master/slave FSM state types.
package axi_lite_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_RESP    = 3'd5
    } master_state_t;

    // Register-file slave states, kept here so the slave can share this package.
    typedef enum logic [1:0] {
        SL_IDLE    = 2'd0,
        SL_WR_DATA = 2'd1,
        SL_WR_RESP = 2'd2,
        SL_RD_DATA = 2'd3
    } slave_state_t;

endpackage

// File: rtl/axi4_lite_master_if.sv
// AXI4-Lite bus bundle (M_ signal set) with master and slave views.
interface axi4_lite_master_if #(
    parameter int ADDRESS    = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDRESS-1:0]      M_AWADDR;
    logic                    M_AWVALID;
    logic                    M_AWREADY;
    logic [DATA_WIDTH-1:0]   M_WDATA;
    logic [DATA_WIDTH/8-1:0] M_WSTRB;
    logic                    M_WVALID;
    logic                    M_WREADY;
    logic [1:0]              M_BRESP;
    logic                    M_BVALID;
    logic                    M_BREADY;
    logic [ADDRESS-1:0]      M_ARADDR;
    logic                    M_ARVALID;
    logic                    M_ARREADY;
    logic [DATA_WIDTH-1:0]   M_RDATA;
    logic [1:0]              M_RRESP;
    logic                    M_RVALID;
    logic                    M_RREADY;

    modport master (
        output M_AWADDR, M_AWVALID, input M_AWREADY,
        output M_WDATA, M_WSTRB, M_WVALID, input M_WREADY,
        input  M_BRESP, M_BVALID, output M_BREADY,
        output M_ARADDR, M_ARVALID, input M_ARREADY,
        input  M_RDATA, M_RRESP, M_RVALID, output M_RREADY
    );

    modport slave (
        input  M_AWADDR, M_AWVALID, output M_AWREADY,
        input  M_WDATA, M_WSTRB, M_WVALID, output M_WREADY,
        output M_BRESP, M_BVALID, input M_BREADY,
        input  M_ARADDR, M_ARVALID, output M_ARREADY,
        output M_RDATA, M_RRESP, M_RVALID, input M_RREADY
    );
endinterface

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one local command in, one response out.
// Optional AXI_LITE_MASTER_ERRCNT_EN adds a saturating non-OKAY response counter (err_count).
//
// state      | meaning
// IDLE       | cmd_ready high, waiting for a command
// WR_REQ     | AW and W offered, each dropped after its own handshake
// WR_RESP    | BREADY high, waiting for BVALID
// RD_REQ     | ARVALID high, waiting for ARREADY
// RD_DATA    | RREADY high, waiting for RVALID
// RESP       | rsp_valid high, waiting for rsp_ready
module axi4_lite_master
    import axi_lite_pkg::*;
#(
    parameter int ADDRESS    = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDRESS-1:0]      cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
`ifdef AXI_LITE_MASTER_ERRCNT_EN
    output logic [15:0]             err_count,
`endif
    axi4_lite_master_if.master      m_axi
);

    localparam int STRB_W = DATA_WIDTH / 8;

    master_state_t         state_q, state_d;
    logic [ADDRESS-1:0]    addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic                  write_q;
    logic                  aw_done_q, w_done_q;

    logic                  cmd_hs, aw_hs, w_hs, resp_hs;
    logic [1:0]            resp_in;
    logic [DATA_WIDTH-1:0] rdata_in;

    // Every bus control output decodes registered state, so reset drops them at once.
    assign cmd_ready       = (state_q == ST_IDLE);
    assign rsp_valid       = (state_q == ST_RESP);
    assign m_axi.M_AWVALID = (state_q == ST_WR_REQ) && !aw_done_q;
    assign m_axi.M_WVALID  = (state_q == ST_WR_REQ) && !w_done_q;
    assign m_axi.M_BREADY  = (state_q == ST_WR_RESP);
    assign m_axi.M_ARVALID = (state_q == ST_RD_REQ);
    assign m_axi.M_RREADY  = (state_q == ST_RD_DATA);
    assign m_axi.M_AWADDR  = addr_q;
    assign m_axi.M_ARADDR  = addr_q;
    assign m_axi.M_WDATA   = wdata_q;
    assign m_axi.M_WSTRB   = wstrb_q;

    assign cmd_hs   = cmd_valid && cmd_ready;
    assign aw_hs    = m_axi.M_AWVALID && m_axi.M_AWREADY;
    assign w_hs     = m_axi.M_WVALID && m_axi.M_WREADY;
    assign resp_hs  = (m_axi.M_BREADY && m_axi.M_BVALID) || (m_axi.M_RREADY && m_axi.M_RVALID);
    assign resp_in  = write_q ? m_axi.M_BRESP : m_axi.M_RRESP;
    assign rdata_in = write_q ? '0 : m_axi.M_RDATA;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = cmd_write ? ST_WR_REQ : ST_RD_REQ;
                end
            end
            ST_WR_REQ: begin
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    state_d = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (m_axi.M_BVALID) begin
                    state_d = ST_RESP;
                end
            end
            ST_RD_REQ: begin
                if (m_axi.M_ARREADY) begin
                    state_d = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (m_axi.M_RVALID) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            write_q   <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= 2'b00;
        end else begin
            if (cmd_hs) begin
                addr_q    <= cmd_addr;
                wdata_q   <= cmd_wdata;
                wstrb_q   <= cmd_wstrb;
                write_q   <= cmd_write;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end
            if (aw_hs) begin
                aw_done_q <= 1'b1;
            end
            if (w_hs) begin
                w_done_q <= 1'b1;
            end
            if (resp_hs) begin
                rsp_rdata <= rdata_in;
                rsp_resp  <= resp_in;
            end
        end
    end

`ifdef AXI_LITE_MASTER_ERRCNT_EN
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            err_count <= 16'd0;
        end else if (resp_hs && (resp_in != OKAY) && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/axi4_lite_master.md
Name: axi4_lite_master

Overview:
- Single-outstanding AXI4-Lite initiator. Turns one local command (read or write) into the matching AXI4-Lite channel handshakes and returns one response.
- Drives the same M_/S_ signal set our register-file slaves consume. Used by test harnesses and control logic to reach any AXI4-Lite slave in the design.
- Strictly one transaction in flight. No reordering, no pipelining across commands.

Parameters:
ADDRESS, 32, address width of cmd_addr and M_AWADDR/M_ARADDR
DATA_WIDTH, 32, data width; WSTRB width is DATA_WIDTH/8

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESETN  in  1  asynchronous active-low reset
cmd_valid  in  1  local command request
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDRESS  target address
cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
cmd_wstrb  in  DATA_WIDTH/8  write strobes (ignored for reads)
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
rsp_resp  out  2  captured BRESP or RRESP
M_AWADDR  out  ADDRESS, M_AWVALID  out  1, M_AWREADY  in  1
M_WDATA  out  DATA_WIDTH, M_WSTRB  out  DATA_WIDTH/8, M_WVALID  out  1, M_WREADY  in  1
M_BRESP  in  2, M_BVALID  in  1, M_BREADY  out  1
M_ARADDR  out  ADDRESS, M_ARVALID  out  1, M_ARREADY  in  1
M_RDATA  in  DATA_WIDTH, M_RRESP  in  2, M_RVALID  in  1, M_RREADY  out  1

Behaviour:
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP.
- Reset: state=IDLE. All valids and readies low. rsp_rdata=0, rsp_resp=0, address/data registers 0. Reset is asynchronous, so assertion mid-transaction drops every valid/ready immediately and abandons the transaction.
- cmd_ready = (state==IDLE). Combinational from state only, never from cmd_valid.
- On command accept: latch addr, wdata, wstrb and write flag.
  - Write: go to WR_REQ and raise M_AWVALID and M_WVALID together on the next cycle.
  - Read: go to RD_REQ and raise M_ARVALID on the next cycle.
- WR_REQ:
  - M_AWVALID drops in the cycle after its AW handshake. M_WVALID drops in the cycle after its W handshake. The two handshakes are tracked independently and may occur in either order or the same cycle.
  - A valid never drops before its handshake.
  - AW/W address, data and strobe stay stable while their valid is high.
  - When both handshakes are done, go to WR_RESP.
- WR_RESP: M_BREADY=1. On M_BVALID, capture rsp_resp=M_BRESP and rsp_rdata=0, then go to RESP.
- RD_REQ: M_ARVALID=1 until M_ARREADY, then go to RD_DATA.
- RD_DATA: M_RREADY=1. On M_RVALID, capture M_RDATA and M_RRESP, then go to RESP.
- RESP: rsp_valid=1 with stable rsp_rdata/rsp_resp. On rsp_ready, go to IDLE. A new command can be accepted the cycle after.
- Minimum latency with a zero-wait slave: command accept (cycle 0), AW+W handshake (1), B handshake (2), rsp_valid (3). Reads follow the same pattern: AR (1), R (2), rsp_valid (3).
- BREADY and RREADY are asserted only in their wait states, never speculatively.
- Non-OKAY responses are passed through unchanged. The block neither retries nor aborts.
- An idle slave that never responds leaves the block waiting forever. Handling that is the system's job.

Optional Feature:
- Macro: AXI_LITE_MASTER_ERRCNT_EN.
- When defined, the block adds output err_count[15:0]. It increments by 1 on every B or R handshake whose response is not 2'b00. It saturates at 16'hFFFF and resets to 0 on ARESETN.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- Shared package axi_lite_pkg holds:
  - resp constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11;
  - the master state enum typedef;
  - the slave state enum, so the existing slave can migrate to it later.
- No sub-module is required. The whole block is one FSM plus capture registers.

Test Plan:
- Zero-wait slave, write addr=0x4 data=0xDEADBEEF wstrb=4'hF: AWVALID/WVALID high 1 cycle, rsp_valid at cycle 3 with rsp_resp=0 and rsp_rdata=0. A read of addr 0x4 then returns rsp_rdata=0xDEADBEEF.
- Slave asserts AWREADY 3 cycles before WREADY: AWVALID drops after its handshake while WVALID stays high and stable until the W handshake. BREADY rises only after both handshakes.
- Read with RVALID delayed 5 cycles and RRESP=2'b10: RREADY held high throughout, rsp_resp=2'b10. With ERRCNT_EN, err_count goes 0→1.
- rsp_ready held low 4 cycles, with cmd_valid high for a new command: rsp_valid, rsp_rdata and rsp_resp stay stable and cmd_ready stays 0. The new command is accepted the cycle after the response handshake.
- ARESETN pulsed low while in WR_REQ: AWVALID and WVALID fall in the same cycle, asynchronously. After release the block is in IDLE with cmd_ready=1, and a following read completes normally.
- With ERRCNT_EN, force 65537 DECERR responses: err_count saturates at 16'hFFFF.
